bcd_sevenseg_scan: RTL and testbench

- Downstream consumer of the signed binary-to-BCD converter's outputs: sign, hundreds, tens and ones digits plus data_ready.
- Latches each completed conversion and time-multiplexes it onto a 4-digit common-anode seven-segment display.
- Digit order, left to right: sign, hundreds, tens, ones.
- Adds leading-zero blanking, invalid-digit flagging, anti-ghosting guard time and a "conversion in progress" decimal point.

---
 rtl/sevenseg_pkg.sv | 49 ++++
 rtl/seg7_decode.sv | 19 +
 rtl/bcd_sevenseg_scan.sv | 148 ++++++++++++++
 tb/tb_bcd_sevenseg_scan.sv | 318 +++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/sevenseg_pkg.sv
// Shared constants and helpers for the multiplexed seven-segment display.
// Segment vectors are ordered {g,f,e,d,c,b,a} and are active-low.
package sevenseg_pkg;

  localparam logic [6:0] SEG_BLANK = 7'h7F;
  localparam logic [6:0] SEG_MINUS = 7'b0111111;
  localparam logic [6:0] SEG_E     = 7'b0000110;

  // Scan position; the value doubles as the anode bit number.
  typedef enum logic [1:0] {
    IdxOnes     = 2'd0,
    IdxTens     = 2'd1,
    IdxHundreds = 2'd2,
    IdxSign     = 2'd3
  } digit_idx_e;

  // Digit pattern ROM; any non-BCD code shows "E".
  function automatic logic [6:0] digit_rom(input logic [3:0] digit);
    logic [6:0] pattern;
    case (digit)
      4'd0:    pattern = 7'b1000000;
      4'd1:    pattern = 7'b1111001;
      4'd2:    pattern = 7'b0100100;
      4'd3:    pattern = 7'b0110000;
      4'd4:    pattern = 7'b0011001;
      4'd5:    pattern = 7'b0010010;
      4'd6:    pattern = 7'b0000010;
      4'd7:    pattern = 7'b1111000;
      4'd8:    pattern = 7'b0000000;
      4'd9:    pattern = 7'b0010000;
      default: pattern = SEG_E;
    endcase
    return pattern;
  endfunction

  // Active-low one-hot anode select; an[3] is the leftmost (sign) digit.
  function automatic logic [3:0] idx_to_an(input logic [1:0] idx);
    logic [3:0] an;
    unique case (digit_idx_e'(idx))
      IdxOnes:     an = 4'b1110;
      IdxTens:     an = 4'b1101;
      IdxHundreds: an = 4'b1011;
      IdxSign:     an = 4'b0111;
      default:     an = 4'b1111;
    endcase
    return an;
  endfunction

endpackage

// File: rtl/seg7_decode.sv
// Combinational BCD digit to active-low seven-segment decoder with blanking.
// Invalid codes (10..15) always show "E", even when blank is requested.
module seg7_decode
  import sevenseg_pkg::*;
(
  input  logic [3:0] digit,
  input  logic       blank,
  output logic [6:0] pattern
);

  // Decode the digit; blanking only applies to valid BCD codes.
  always_comb begin
    pattern = digit_rom(digit);
    if (blank && (digit <= 4'd9)) begin
      pattern = SEG_BLANK;
    end
  end

endmodule

// File: rtl/bcd_sevenseg_scan.sv
// Latches a signed BCD conversion result and scans it onto a 4-digit
// common-anode display (sign, hundreds, tens, ones from left to right),
// with leading-zero blanking, anti-ghosting guard time and a busy dot.
module bcd_sevenseg_scan
  import sevenseg_pkg::*;
#(
  parameter int unsigned REFRESH_DIV = 50000,
  parameter int unsigned GUARD       = 500
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       sign,
  input  logic [3:0] hundreds,
  input  logic [3:0] tens,
  input  logic [3:0] ones,
  input  logic       data_ready,
  output logic [6:0] seg,
  output logic [3:0] an,
  output logic       dp
);

  localparam logic [15:0] DivLast  = 16'(REFRESH_DIV - 1);
  localparam logic [15:0] GuardCnt = 16'(GUARD);

  logic [15:0] div_cnt;
  logic [1:0]  idx;
  logic        div_wrap;

  logic        valid;
  logic        disp_sign;
  logic [3:0]  disp_hundreds;
  logic [3:0]  disp_tens;
  logic [3:0]  disp_ones;

  logic [3:0]  dec_digit;
  logic        dec_blank;
  logic [6:0]  dec_pattern;

  logic [6:0]  seg_next;
  logic [3:0]  an_next;
  logic        dp_next;

  assign div_wrap = (div_cnt == DivLast);

  // Refresh divider and scan index; idx steps on the divider wrap cycle.
  always_ff @(posedge clk) begin
    if (rst) begin
      div_cnt <= '0;
      idx     <= 2'd0;
    end else if (div_wrap) begin
      div_cnt <= '0;
      idx     <= idx + 2'd1;
    end else begin
      div_cnt <= div_cnt + 16'd1;
    end
  end

  // Capture registers: sample the converter whenever its result is valid.
  always_ff @(posedge clk) begin
    if (rst) begin
      valid         <= 1'b0;
      disp_sign     <= 1'b0;
      disp_hundreds <= 4'd0;
      disp_tens     <= 4'd0;
      disp_ones     <= 4'd0;
    end else if (data_ready) begin
      valid         <= 1'b1;
      disp_sign     <= sign;
      disp_hundreds <= hundreds;
      disp_tens     <= tens;
      disp_ones     <= ones;
    end
  end

  // Select the digit under scan and its leading-zero blank condition.
  // A non-zero (including invalid) higher digit keeps lower digits visible.
  always_comb begin
    dec_digit = 4'd0;
    dec_blank = 1'b1;
    unique case (digit_idx_e'(idx))
      IdxOnes: begin
        dec_digit = disp_ones;
        dec_blank = 1'b0;
      end
      IdxTens: begin
        dec_digit = disp_tens;
        dec_blank = (disp_hundreds == 4'd0) && (disp_tens == 4'd0);
      end
      IdxHundreds: begin
        dec_digit = disp_hundreds;
        dec_blank = (disp_hundreds == 4'd0);
      end
      IdxSign: begin
        dec_digit = 4'd0;
        dec_blank = 1'b1;
      end
      default: begin
        dec_digit = 4'd0;
        dec_blank = 1'b1;
      end
    endcase
  end

  seg7_decode u_seg7_decode (
    .digit   (dec_digit),
    .blank   (dec_blank),
    .pattern (dec_pattern)
  );

  // Next output values; anodes stay dark before the first capture and
  // during the guard window at the start of each slot.
  always_comb begin
    seg_next = SEG_BLANK;
    an_next  = 4'hF;
    dp_next  = 1'b1;

    if (valid) begin
      if (digit_idx_e'(idx) == IdxSign) begin
        seg_next = disp_sign ? SEG_MINUS : SEG_BLANK;
      end else begin
        seg_next = dec_pattern;
      end
    end

    if (valid && !(div_cnt < GuardCnt)) begin
      an_next = idx_to_an(idx);
    end

    // Busy dot on the ones digit while the converter is mid-conversion.
    if ((digit_idx_e'(idx) == IdxOnes) && valid && !data_ready) begin
      dp_next = 1'b0;
    end
  end

  // Output registers.
  always_ff @(posedge clk) begin
    if (rst) begin
      seg <= SEG_BLANK;
      an  <= 4'hF;
      dp  <= 1'b1;
    end else begin
      seg <= seg_next;
      an  <= an_next;
      dp  <= dp_next;
    end
  end

endmodule

// File: tb/tb_bcd_sevenseg_scan.sv
// Self-checking bench for bcd_sevenseg_scan with REFRESH_DIV=4, GUARD=1.
// A cycle model pushes expected {seg,an,dp} into a queue each clock; the
// scenario tasks pop and compare after the edge.
module tb_bcd_sevenseg_scan;

  localparam int unsigned RefreshDiv = 4;
  localparam int unsigned Guard      = 1;

  logic       clk;
  logic       rst;
  logic       sign;
  logic [3:0] hundreds;
  logic [3:0] tens;
  logic [3:0] ones;
  logic       data_ready;
  logic [6:0] seg;
  logic [3:0] an;
  logic       dp;

  bcd_sevenseg_scan #(
    .REFRESH_DIV (RefreshDiv),
    .GUARD       (Guard)
  ) dut (
    .clk        (clk),
    .rst        (rst),
    .sign       (sign),
    .hundreds   (hundreds),
    .tens       (tens),
    .ones       (ones),
    .data_ready (data_ready),
    .seg        (seg),
    .an         (an),
    .dp         (dp)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int errors = 0;
  int checks = 0;
  int cycle  = 0;

  logic [11:0] exp_q[$];

  // Reference model state.
  int         m_div   = 0;
  int         m_idx   = 0;
  logic       m_valid = 1'b0;
  logic       m_sign  = 1'b0;
  logic [3:0] m_h     = 4'd0;
  logic [3:0] m_t     = 4'd0;
  logic [3:0] m_o     = 4'd0;

  function automatic logic [6:0] exp_digit(input logic [3:0] d, input logic blank);
    logic [6:0] p;
    case (d)
      4'd0: p = 7'b1000000;
      4'd1: p = 7'b1111001;
      4'd2: p = 7'b0100100;
      4'd3: p = 7'b0110000;
      4'd4: p = 7'b0011001;
      4'd5: p = 7'b0010010;
      4'd6: p = 7'b0000010;
      4'd7: p = 7'b1111000;
      4'd8: p = 7'b0000000;
      4'd9: p = 7'b0010000;
      default: p = 7'b0000110;
    endcase
    if (blank && d <= 4'd9) p = 7'h7F;
    return p;
  endfunction

  function automatic logic [11:0] model_out();
    logic [6:0] s;
    logic [3:0] a;
    logic       d;
    if (rst) return {7'h7F, 4'hF, 1'b1};
    s = 7'h7F;
    if (m_valid) begin
      case (m_idx)
        3: s = m_sign ? 7'b0111111 : 7'h7F;
        2: s = exp_digit(m_h, m_h == 4'd0);
        1: s = exp_digit(m_t, (m_h == 4'd0) && (m_t == 4'd0));
        default: s = exp_digit(m_o, 1'b0);
      endcase
    end
    a = (!m_valid || m_div < int'(Guard)) ? 4'hF : ~(4'b0001 << m_idx);
    d = (m_idx == 0 && m_valid && !data_ready) ? 1'b0 : 1'b1;
    return {s, a, d};
  endfunction

  // Push the expectation for this edge, clock, then advance the model.
  task automatic tick();
    exp_q.push_back(model_out());
    @(posedge clk);
    cycle++;
    if (rst) begin
      m_div = 0; m_idx = 0; m_valid = 1'b0;
      m_sign = 1'b0; m_h = 4'd0; m_t = 4'd0; m_o = 4'd0;
    end else begin
      if (data_ready) begin
        m_valid = 1'b1; m_sign = sign; m_h = hundreds; m_t = tens; m_o = ones;
      end
      if (m_div == int'(RefreshDiv) - 1) begin
        m_div = 0;
        m_idx = (m_idx + 1) % 4;
      end else begin
        m_div++;
      end
    end
    #1;
  endtask

  task automatic set_data(input logic s, input logic [3:0] h, input logic [3:0] t,
                          input logic [3:0] o, input logic rdy);
    sign = s; hundreds = h; tens = t; ones = o; data_ready = rdy;
  endtask

  task automatic test_reset();
    logic [11:0] e;
    rst = 1'b1;
    set_data(1'b0, 4'd0, 4'd0, 4'd0, 1'b0);
    for (int i = 0; i < 2; i++) begin
      tick();
      e = exp_q.pop_front();
      checks++;
      if ({seg, an, dp} !== e) begin
        errors++;
        $display("FAIL reset cyc=%0d: got seg=%h an=%h dp=%b, expected seg=%h an=%h dp=%b",
                 cycle, seg, an, dp, e[11:5], e[4:1], e[0]);
      end
    end
    rst = 1'b0;
    for (int i = 0; i < 40; i++) begin
      tick();
      e = exp_q.pop_front();
      checks++;
      if ({seg, an, dp} !== {7'h7F, 4'hF, 1'b1} || {seg, an, dp} !== e) begin
        errors++;
        $display("FAIL idle_no_data cyc=%0d: got seg=%h an=%h dp=%b, expected seg=%h an=%h dp=%b",
                 cycle, seg, an, dp, e[11:5], e[4:1], e[0]);
      end
    end
  endtask

  task automatic test_negative_127();
    logic [11:0] e;
    int guard_cycles = 0;
    set_data(1'b1, 4'd1, 4'd2, 4'd7, 1'b1);
    for (int i = 0; i < 17; i++) begin
      tick();
      e = exp_q.pop_front();
      if (i > 0 && an === 4'hF) guard_cycles++;
      checks++;
      if ({seg, an, dp} !== e) begin
        errors++;
        $display("FAIL neg127 cyc=%0d: got seg=%h an=%h dp=%b, expected seg=%h an=%h dp=%b",
                 cycle, seg, an, dp, e[11:5], e[4:1], e[0]);
      end
    end
    checks++;
    if (guard_cycles != 4) begin
      errors++;
      $display("FAIL guard_count: got %0d dark cycles per 16, expected 4", guard_cycles);
    end
  endtask

  task automatic test_blanking();
    logic [11:0] e;
    set_data(1'b0, 4'd0, 4'd0, 4'd5, 1'b1);
    for (int i = 0; i < 18; i++) begin
      tick();
      e = exp_q.pop_front();
      checks++;
      if ({seg, an, dp} !== e) begin
        errors++;
        $display("FAIL blank_005 cyc=%0d: got seg=%h an=%h dp=%b, expected seg=%h an=%h dp=%b",
                 cycle, seg, an, dp, e[11:5], e[4:1], e[0]);
      end
    end
  endtask

  task automatic test_invalid();
    logic [11:0] e;
    set_data(1'b0, 4'd0, 4'd4, 4'd0, 1'b1);
    for (int i = 0; i < 18; i++) begin
      tick();
      e = exp_q.pop_front();
      checks++;
      if ({seg, an, dp} !== e) begin
        errors++;
        $display("FAIL tens_only cyc=%0d: got seg=%h an=%h dp=%b, expected seg=%h an=%h dp=%b",
                 cycle, seg, an, dp, e[11:5], e[4:1], e[0]);
      end
    end
    set_data(1'b0, 4'd12, 4'd0, 4'd0, 1'b1);
    for (int i = 0; i < 18; i++) begin
      tick();
      e = exp_q.pop_front();
      checks++;
      if ({seg, an, dp} !== e) begin
        errors++;
        $display("FAIL invalid_h cyc=%0d: got seg=%h an=%h dp=%b, expected seg=%h an=%h dp=%b",
                 cycle, seg, an, dp, e[11:5], e[4:1], e[0]);
      end
    end
  endtask

  task automatic test_hold_dp();
    logic [11:0] e;
    int dp_low = 0;
    set_data(1'b0, 4'd1, 4'd2, 4'd7, 1'b1);
    tick();
    void'(exp_q.pop_front());
    set_data(1'b1, 4'd9, 4'd9, 4'd9, 1'b0);
    for (int i = 0; i < 32; i++) begin
      tick();
      e = exp_q.pop_front();
      if (i >= 1 && i <= 16 && dp === 1'b0) dp_low++;
      checks++;
      if ({seg, an, dp} !== e) begin
        errors++;
        $display("FAIL hold_dp cyc=%0d: got seg=%h an=%h dp=%b, expected seg=%h an=%h dp=%b",
                 cycle, seg, an, dp, e[11:5], e[4:1], e[0]);
      end
    end
    checks++;
    if (dp_low != 4) begin
      errors++;
      $display("FAIL dp_slot_count: got %0d dp-low cycles per 16, expected 4", dp_low);
    end
  endtask

  task automatic test_mid_reset();
    logic [11:0] e;
    bit found = 1'b0;
    set_data(1'b1, 4'd3, 4'd4, 4'd5, 1'b1);
    for (int i = 0; i < 64 && !found; i++) begin
      if (m_div == 2 && m_idx == 2) begin
        found = 1'b1;
      end else begin
        tick();
        e = exp_q.pop_front();
        checks++;
        if ({seg, an, dp} !== e) begin
          errors++;
          $display("FAIL pre_reset cyc=%0d: got seg=%h an=%h dp=%b, expected seg=%h an=%h dp=%b",
                   cycle, seg, an, dp, e[11:5], e[4:1], e[0]);
        end
      end
    end
    checks++;
    if (!found) begin
      errors++;
      $display("FAIL reach_slot: got no div_cnt=2 idx=2 within 64 cycles, expected one");
    end
    rst = 1'b1;
    tick();
    e = exp_q.pop_front();
    checks++;
    if ({seg, an, dp} !== {7'h7F, 4'hF, 1'b1} || {seg, an, dp} !== e) begin
      errors++;
      $display("FAIL mid_reset: got seg=%h an=%h dp=%b, expected seg=7f an=f dp=1", seg, an, dp);
    end
    rst = 1'b0;
    set_data(1'b0, 4'd0, 4'd6, 4'd8, 1'b1);
    tick();
    void'(exp_q.pop_front());
    tick();
    e = exp_q.pop_front();
    checks++;
    if (an !== 4'hE || seg !== 7'b0000000) begin
      errors++;
      $display("FAIL restart_idx0: got an=%h seg=%h, expected an=e seg=00", an, seg);
    end
    for (int i = 0; i < 16; i++) begin
      tick();
      e = exp_q.pop_front();
      checks++;
      if ({seg, an, dp} !== e) begin
        errors++;
        $display("FAIL post_reset cyc=%0d: got seg=%h an=%h dp=%b, expected seg=%h an=%h dp=%b",
                 cycle, seg, an, dp, e[11:5], e[4:1], e[0]);
      end
    end
  endtask

  // New data every cycle, including captures on idx wrap cycles.
  task automatic test_back_to_back();
    logic [11:0] e;
    for (int i = 0; i < 48; i++) begin
      set_data(1'($urandom_range(0, 1)), 4'($urandom_range(0, 15)),
               4'($urandom_range(0, 15)), 4'($urandom_range(0, 15)),
               1'($urandom_range(0, 3) != 0));
      tick();
      e = exp_q.pop_front();
      checks++;
      if ({seg, an, dp} !== e) begin
        errors++;
        $display("FAIL back_to_back cyc=%0d: got seg=%h an=%h dp=%b, expected seg=%h an=%h dp=%b",
                 cycle, seg, an, dp, e[11:5], e[4:1], e[0]);
      end
    end
  endtask

  initial begin
    test_reset();
    test_negative_127();
    test_blanking();
    test_invalid();
    test_hold_dp();
    test_mid_reset();
    test_back_to_back();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
